operand_stack: RTL and testbench

- LIFO operand stack feeding the ALU in the single-cycle stack CPU.
- Presents top-of-stack (tos) and next-on-stack (nos) combinationally. nos drives ALU operand1; tos drives ALU operand2 and the branch-zero test.
- Commits one stack operation per clock: push, pop, unary replace, binary replace (pop two, push ALU result), dup, swap or clear.

---
 rtl/stack_pkg.sv | 18 +
 rtl/stack_ram.sv | 39 +++
 rtl/operand_stack.sv | 191 +++++++++++++++++++
 tb/tb_operand_stack.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: opcode encodings and the default
// datapath width. Imported by operand_stack and stack_ram.
package stack_pkg;

  localparam int STK_WIDTH = 32;

  typedef logic [2:0] stk_op_t;

  localparam stk_op_t STK_NOP   = 3'b000;
  localparam stk_op_t STK_PUSH  = 3'b001;
  localparam stk_op_t STK_POP   = 3'b010;
  localparam stk_op_t STK_REP1  = 3'b011;
  localparam stk_op_t STK_REP2  = 3'b100;
  localparam stk_op_t STK_DUP   = 3'b101;
  localparam stk_op_t STK_SWAP  = 3'b110;
  localparam stk_op_t STK_CLEAR = 3'b111;

endpackage

// File: rtl/stack_ram.sv
// Storage array for the operand stack. DEPTH x WIDTH registers with no reset,
// two asynchronous read ports (top and next entry) and two write ports. The
// second write port exists so SWAP can update both entries in one edge; if
// both ports ever target the same address, port 1 wins.
module stack_ram
  import stack_pkg::*;
#(
  parameter int WIDTH = STK_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we0,
  input  logic [$clog2(DEPTH)-1:0] i_waddr0,
  input  logic [WIDTH-1:0]         i_wdata0,
  input  logic                     i_we1,
  input  logic [$clog2(DEPTH)-1:0] i_waddr1,
  input  logic [WIDTH-1:0]         i_wdata1,
  input  logic [$clog2(DEPTH)-1:0] i_raddr0,
  input  logic [$clog2(DEPTH)-1:0] i_raddr1,
  output logic [WIDTH-1:0]         o_rdata0,
  output logic [WIDTH-1:0]         o_rdata1
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Commit the primary write and, when requested, the secondary write.
  always_ff @(posedge clk) begin
    if (i_we0) begin
      r_mem[i_waddr0] <= i_wdata0;
    end
    if (i_we1) begin
      r_mem[i_waddr1] <= i_wdata1;
    end
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/operand_stack.sv
// LIFO operand stack feeding the ALU. Presents top-of-stack and
// next-on-stack combinationally and commits one operation per clock.
// Optional feature macro: OPERAND_STACK_DUPSWAP_EN enables DUP and SWAP;
// without it those opcodes behave as NOP and raise no error.
module operand_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = STK_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         tos,
  output logic [WIDTH-1:0]         nos,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     err_underflow,
  output logic                     err_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [CW-1:0]    r_count;
  logic             r_errUnder;
  logic             r_errOver;

  logic [CW-1:0]    w_nextCount;
  logic             w_setUnder;
  logic             w_setOver;
  logic             w_clear;
  logic             w_we0;
  logic [AW-1:0]    w_waddr0;
  logic [WIDTH-1:0] w_wdata0;
  logic             w_we1;
  logic [AW-1:0]    w_waddr1;
  logic [WIDTH-1:0] w_wdata1;
  logic [AW-1:0]    w_addrTop;
  logic [AW-1:0]    w_addrNos;
  logic [AW-1:0]    w_addrFree;
  logic [WIDTH-1:0] w_rdTop;
  logic [WIDTH-1:0] w_rdNos;
  logic             w_hasOne;
  logic             w_hasTwo;
  logic             w_full;

  // Addresses are count-relative; when count is too small these wrap, but
  // the read data is masked and the writes are suppressed by the decode.
  assign w_addrTop  = AW'(r_count - CW'(1));
  assign w_addrNos  = AW'(r_count - CW'(2));
  assign w_addrFree = AW'(r_count);

  assign w_hasOne = (r_count >= CW'(1));
  assign w_hasTwo = (r_count >= CW'(2));
  assign w_full   = (r_count == FULL_COUNT);

  // Decode the operation into next count, storage writes and error events.
  always_comb begin
    w_nextCount = r_count;
    w_setUnder  = 1'b0;
    w_setOver   = 1'b0;
    w_clear     = 1'b0;
    w_we0       = 1'b0;
    w_waddr0    = w_addrTop;
    w_wdata0    = wdata;
    w_we1       = 1'b0;
    w_waddr1    = w_addrNos;
    w_wdata1    = w_rdTop;
    case (op)
      STK_PUSH: begin
        if (w_full) begin
          w_setOver = 1'b1;
        end else begin
          w_we0       = 1'b1;
          w_waddr0    = w_addrFree;
          w_nextCount = r_count + CW'(1);
        end
      end
      STK_POP: begin
        if (!w_hasOne) begin
          w_setUnder = 1'b1;
        end else begin
          w_nextCount = r_count - CW'(1);
        end
      end
      STK_REP1: begin
        if (!w_hasOne) begin
          w_setUnder = 1'b1;
        end else begin
          w_we0 = 1'b1;
        end
      end
      STK_REP2: begin
        if (!w_hasTwo) begin
          w_setUnder = 1'b1;
        end else begin
          w_we0       = 1'b1;
          w_waddr0    = w_addrNos;
          w_nextCount = r_count - CW'(1);
        end
      end
`ifdef OPERAND_STACK_DUPSWAP_EN
      STK_DUP: begin
        if (!w_hasOne) begin
          w_setUnder = 1'b1;
        end else if (w_full) begin
          w_setOver = 1'b1;
        end else begin
          w_we0       = 1'b1;
          w_waddr0    = w_addrFree;
          w_wdata0    = w_rdTop;
          w_nextCount = r_count + CW'(1);
        end
      end
      STK_SWAP: begin
        if (!w_hasTwo) begin
          w_setUnder = 1'b1;
        end else begin
          w_we0    = 1'b1;
          w_waddr0 = w_addrTop;
          w_wdata0 = w_rdNos;
          w_we1    = 1'b1;
          w_waddr1 = w_addrNos;
          w_wdata1 = w_rdTop;
        end
      end
`endif
      STK_CLEAR: begin
        w_nextCount = '0;
        w_clear     = 1'b1;
      end
      default: begin
        w_nextCount = r_count;
      end
    endcase
  end

  // Entry count; reset asynchronously, otherwise follows the decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_nextCount;
    end
  end

  // Sticky error flags; only reset or CLEAR lowers them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_errUnder <= 1'b0;
      r_errOver  <= 1'b0;
    end else if (w_clear) begin
      r_errUnder <= 1'b0;
      r_errOver  <= 1'b0;
    end else begin
      r_errUnder <= r_errUnder | w_setUnder;
      r_errOver  <= r_errOver  | w_setOver;
    end
  end

  // Writes are gated by reset so an op presented during reset is dropped.
  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk      (clk),
    .i_we0    (w_we0 & ~reset),
    .i_waddr0 (w_waddr0),
    .i_wdata0 (w_wdata0),
    .i_we1    (w_we1 & ~reset),
    .i_waddr1 (w_waddr1),
    .i_wdata1 (w_wdata1),
    .i_raddr0 (w_addrTop),
    .i_raddr1 (w_addrNos),
    .o_rdata0 (w_rdTop),
    .o_rdata1 (w_rdNos)
  );

  assign tos           = w_hasOne ? w_rdTop : '0;
  assign nos           = w_hasTwo ? w_rdNos : '0;
  assign count         = r_count;
  assign empty         = (r_count == '0);
  assign full          = w_full;
  assign err_underflow = r_errUnder;
  assign err_overflow  = r_errOver;

endmodule

// File: tb/tb_operand_stack.sv
// Directed testbench for operand_stack (WIDTH=32, DEPTH=16). Expected values
// are hand-computed; DUP/SWAP expectations follow OPERAND_STACK_DUPSWAP_EN.
module tb_operand_stack;
  import stack_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  op;
  logic [31:0] wdata;
  logic [31:0] tos;
  logic [31:0] nos;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        err_underflow;
  logic        err_overflow;

  int compareCount;
  int failCount;

  operand_stack #(
    .WIDTH (32),
    .DEPTH (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .wdata         (wdata),
    .tos           (tos),
    .nos           (nos),
    .count         (count),
    .empty         (empty),
    .full          (full),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one op, let it commit on the next rising edge, then settle.
  task automatic applyStimulus(input logic [2:0] stepOp, input logic [31:0] stepData);
    op    = stepOp;
    wdata = stepData;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Linear sequence of directed steps.
  initial begin
    compareCount = 0;
    failCount    = 0;
    reset = 1'b1;
    op    = STK_NOP;
    wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full",  32'(full),  32'd0);
    checkOutput("rst_tos",   tos, 32'd0);
    checkOutput("rst_nos",   nos, 32'd0);
    checkOutput("rst_under", 32'(err_underflow), 32'd0);
    checkOutput("rst_over",  32'(err_overflow),  32'd0);

    applyStimulus(STK_PUSH, 32'd5);
    applyStimulus(STK_PUSH, 32'd7);
    checkOutput("push2_count", 32'(count), 32'd2);
    checkOutput("push2_tos",   tos, 32'd7);
    checkOutput("push2_nos",   nos, 32'd5);
    applyStimulus(STK_REP2, 32'd12);
    checkOutput("rep2_count", 32'(count), 32'd1);
    checkOutput("rep2_tos",   tos, 32'd12);
    checkOutput("rep2_nos",   nos, 32'd0);

    applyStimulus(STK_CLEAR, 32'd0);
    applyStimulus(STK_POP, 32'd0);
    checkOutput("upop_count", 32'(count), 32'd0);
    checkOutput("upop_under", 32'(err_underflow), 32'd1);
    checkOutput("upop_tos",   tos, 32'd0);
    applyStimulus(STK_PUSH, 32'd3);
    checkOutput("sticky_count", 32'(count), 32'd1);
    checkOutput("sticky_tos",   tos, 32'd3);
    checkOutput("sticky_under", 32'(err_underflow), 32'd1);
    applyStimulus(STK_CLEAR, 32'd0);
    checkOutput("clr_count", 32'(count), 32'd0);
    checkOutput("clr_under", 32'(err_underflow), 32'd0);
    checkOutput("clr_empty", 32'(empty), 32'd1);

    for (int i = 1; i <= 16; i++) begin
      applyStimulus(STK_PUSH, 32'(i));
    end
    checkOutput("fill_full",  32'(full),  32'd1);
    checkOutput("fill_count", 32'(count), 32'd16);
    checkOutput("fill_tos",   tos, 32'd16);
    checkOutput("fill_nos",   nos, 32'd15);
    applyStimulus(STK_PUSH, 32'd99);
    checkOutput("ovf_count", 32'(count), 32'd16);
    checkOutput("ovf_tos",   tos, 32'd16);
    checkOutput("ovf_over",  32'(err_overflow), 32'd1);
    checkOutput("ovf_under", 32'(err_underflow), 32'd0);
    applyStimulus(STK_POP, 32'd0);
    checkOutput("pop15_count", 32'(count), 32'd15);
    checkOutput("pop15_tos",   tos, 32'd15);
    checkOutput("pop15_nos",   nos, 32'd14);
    checkOutput("pop15_full",  32'(full), 32'd0);
    checkOutput("pop15_over",  32'(err_overflow), 32'd1);
    applyStimulus(STK_CLEAR, 32'd0);
    checkOutput("clr2_over",  32'(err_overflow), 32'd0);
    checkOutput("clr2_count", 32'(count), 32'd0);

    applyStimulus(STK_PUSH, 32'd4);
    applyStimulus(STK_PUSH, 32'd9);
    applyStimulus(STK_SWAP, 32'd0);
`ifdef OPERAND_STACK_DUPSWAP_EN
    checkOutput("swap_tos", tos, 32'd4);
    checkOutput("swap_nos", nos, 32'd9);
`else
    checkOutput("swap_tos", tos, 32'd9);
    checkOutput("swap_nos", nos, 32'd4);
`endif
    applyStimulus(STK_DUP, 32'd0);
`ifdef OPERAND_STACK_DUPSWAP_EN
    checkOutput("dup_count", 32'(count), 32'd3);
    checkOutput("dup_tos",   tos, 32'd4);
    checkOutput("dup_nos",   nos, 32'd4);
`else
    checkOutput("dup_count", 32'(count), 32'd2);
    checkOutput("dup_tos",   tos, 32'd9);
    checkOutput("dup_nos",   nos, 32'd4);
`endif
    checkOutput("dup_under", 32'(err_underflow), 32'd0);
    checkOutput("dup_over",  32'(err_overflow),  32'd0);

    applyStimulus(STK_CLEAR, 32'd0);
    applyStimulus(STK_PUSH, 32'd8);
    applyStimulus(STK_REP2, 32'd1);
    checkOutput("urep2_count", 32'(count), 32'd1);
    checkOutput("urep2_tos",   tos, 32'd8);
    checkOutput("urep2_under", 32'(err_underflow), 32'd1);
    applyStimulus(STK_REP1, 32'hFFFF_FFF7);
    checkOutput("rep1_tos",   tos, 32'hFFFF_FFF7);
    checkOutput("rep1_count", 32'(count), 32'd1);

    applyStimulus(STK_CLEAR, 32'd0);
    applyStimulus(STK_PUSH, 32'd6);
    applyStimulus(STK_PUSH, 32'd2);
    checkOutput("pre_rst_count", 32'(count), 32'd2);
    op    = STK_PUSH;
    wdata = 32'd11;
    #3;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_count", 32'(count), 32'd0);
    checkOutput("mid_rst_empty", 32'(empty), 32'd1);
    checkOutput("mid_rst_tos",   tos, 32'd0);
    checkOutput("mid_rst_nos",   nos, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("held_rst_count", 32'(count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(STK_PUSH, 32'd1);
    checkOutput("post_rst_tos",   tos, 32'd1);
    checkOutput("post_rst_count", 32'(count), 32'd1);
    checkOutput("post_rst_nos",   nos, 32'd0);
    op = STK_NOP;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
